// File: rtl/memory_access.sv
// Memory-access stage: EX/MEM latch, branch resolve, data memory,
// MEM/WB latch, plus the ALU-control decoder used by execute.
module memory_access #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instruction,
  input  logic [63:0] branchAddress,
  input  logic [63:0] Results,
  input  logic [63:0] Data2,
  input  logic        zero,
  input  logic        B,
  input  logic        BZ,
  input  logic        BNZ,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        RegWrite,
  output logic [63:0] oldBranchAddress,
  output logic        PCSrc,
  output logic        oldRegWrite,
  output logic [63:0] Data2Write,
  output logic [4:0]  Reg2Write,
  input  logic [10:0] alu_opcode,
  input  logic [1:0]  ALUOp,
  output logic [3:0]  ALUInst
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef struct packed {
    logic [63:0] baddr;
    logic [63:0] res;
    logic [63:0] data2;
    logic [4:0]  rd;
    logic        zero;
    logic        b;
    logic        bz;
    logic        bnz;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
  } ex_mem_t;

  ex_mem_t ex_d;
  ex_mem_t ex_q;

  logic [63:0]   mem [MEM_DEPTH];
  logic [AW-1:0] addr;
  logic [63:0]   rdata;

  always_comb begin
    ex_d          = '0;
    ex_d.baddr    = branchAddress;
    ex_d.res      = Results;
    ex_d.data2    = Data2;
    ex_d.rd       = Instruction[4:0];
    ex_d.zero     = zero;
    ex_d.b        = B;
    ex_d.bz       = BZ;
    ex_d.bnz      = BNZ;
    ex_d.memread  = MemRead;
    ex_d.memwrite = MemWrite;
    ex_d.memtoreg = MemToReg;
    ex_d.regwrite = RegWrite;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign PCSrc = ex_q.b
               | (ex_q.bz & ex_q.zero)
               | (ex_q.bnz & ~ex_q.zero);

  assign oldBranchAddress = ex_q.baddr;

  // Byte offset dropped; upper address bits wrap modulo depth.
  assign addr  = ex_q.res[3 +: AW];
  assign rdata = mem[addr];

  // Contents survive reset; a cleared EX/MEM latch blocks writes.
  always_ff @(posedge clk) begin
    if (ex_q.memwrite) begin
      mem[addr] <= ex_q.data2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Data2Write  <= '0;
      Reg2Write   <= '0;
      oldRegWrite <= 1'b0;
    end else begin
      Data2Write  <= ex_q.memtoreg ? rdata : ex_q.res;
      Reg2Write   <= ex_q.rd;
      oldRegWrite <= ex_q.regwrite;
    end
  end

  logic r_add;
  logic r_sub;
  logic r_and;
  logic r_orr;
  logic i_add;
  logic i_sub;
  logic i_and;
  logic i_orr;

  assign r_add = alu_opcode == 11'b10001011000;
  assign r_sub = alu_opcode == 11'b11001011000;
  assign r_and = alu_opcode == 11'b10001010000;
  assign r_orr = alu_opcode == 11'b10101010000;
  assign i_add = alu_opcode[10:1] == 10'b1001000100;
  assign i_sub = alu_opcode[10:1] == 10'b1101000100;
  assign i_and = alu_opcode[10:1] == 10'b1001001000;
  assign i_orr = alu_opcode[10:1] == 10'b1011001000;

  always_comb begin
    ALUInst = 4'b1111;
    unique case (ALUOp)
      2'b00: ALUInst = 4'b0010;
      2'b01: ALUInst = 4'b0111;
      2'b10: begin
        unique case (1'b1)
          r_add:   ALUInst = 4'b0010;
          r_sub:   ALUInst = 4'b0110;
          r_and:   ALUInst = 4'b0000;
          r_orr:   ALUInst = 4'b0001;
          default: ALUInst = 4'b1111;
        endcase
      end
      2'b11: begin
        unique case (1'b1)
          i_add:   ALUInst = 4'b0010;
          i_sub:   ALUInst = 4'b0110;
          i_and:   ALUInst = 4'b0000;
          i_orr:   ALUInst = 4'b0001;
          default: ALUInst = 4'b1111;
        endcase
      end
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{Instruction[31:5], ex_q.memread};

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed steps plus random traffic
// against a transaction-level model of memory and branches.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] Instruction;
  logic [63:0] branchAddress;
  logic [63:0] Results;
  logic [63:0] Data2;
  logic        zero;
  logic        B;
  logic        BZ;
  logic        BNZ;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        RegWrite;
  logic [63:0] oldBranchAddress;
  logic        PCSrc;
  logic        oldRegWrite;
  logic [63:0] Data2Write;
  logic [4:0]  Reg2Write;
  logic [10:0] alu_opcode;
  logic [1:0]  ALUOp;
  logic [3:0]  ALUInst;

  memory_access #(.MEM_DEPTH(256)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .Instruction(Instruction),
    .branchAddress(branchAddress),
    .Results(Results),
    .Data2(Data2),
    .zero(zero),
    .B(B),
    .BZ(BZ),
    .BNZ(BNZ),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemToReg(MemToReg),
    .RegWrite(RegWrite),
    .oldBranchAddress(oldBranchAddress),
    .PCSrc(PCSrc),
    .oldRegWrite(oldRegWrite),
    .Data2Write(Data2Write),
    .Reg2Write(Reg2Write),
    .alu_opcode(alu_opcode),
    .ALUOp(ALUOp),
    .ALUInst(ALUInst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] ba;
    logic [63:0] res;
    logic [63:0] d2;
    logic        z;
    logic        b;
    logic        bz;
    logic        bnz;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
  } tx_t;

  logic [63:0] mm [256];
  tx_t         prev;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [63:0] a);
    return int'((a >> 3) % 64'd256);
  endfunction

  function automatic logic pc_ref(input tx_t t);
    return t.b || (t.bz && t.z) || (t.bnz && !t.z);
  endfunction

  function automatic logic [3:0] alu_ref(input logic [1:0] op,
                                         input logic [10:0] opc);
    logic [9:0] hi;
    hi = opc[10:1];
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd7;
    if (op == 2'd2) begin
      if (opc == 11'b10001011000) return 4'd2;
      if (opc == 11'b11001011000) return 4'd6;
      if (opc == 11'b10001010000) return 4'd0;
      if (opc == 11'b10101010000) return 4'd1;
      return 4'hF;
    end
    if (hi == 10'b1001000100) return 4'd2;
    if (hi == 10'b1101000100) return 4'd6;
    if (hi == 10'b1001001000) return 4'd0;
    if (hi == 10'b1011001000) return 4'd1;
    return 4'hF;
  endfunction

  function automatic tx_t mem_tx(input logic mw, mr, m2r, rw,
                                 input logic [63:0] res, d2,
                                 input logic [4:0] rd);
    tx_t t;
    t     = '0;
    t.mw  = mw;
    t.mr  = mr;
    t.m2r = m2r;
    t.rw  = rw;
    t.res = res;
    t.d2  = d2;
    t.ins = {27'($urandom), rd};
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    t.ins = $urandom;
    t.ba  = {$urandom, $urandom};
    t.res = {32'($urandom), 21'($urandom), 5'd0,
             3'($urandom_range(0, 7)), 3'($urandom)};
    t.d2  = {$urandom, $urandom};
    {t.z, t.b, t.bz, t.bnz} = 4'($urandom);
    {t.mr, t.mw, t.m2r, t.rw} = 4'($urandom);
    return t;
  endfunction

  task automatic drive(input tx_t t);
    Instruction   = t.ins;
    branchAddress = t.ba;
    Results       = t.res;
    Data2         = t.d2;
    zero          = t.z;
    B             = t.b;
    BZ            = t.bz;
    BNZ           = t.bnz;
    MemRead       = t.mr;
    MemWrite      = t.mw;
    MemToReg      = t.m2r;
    RegWrite      = t.rw;
  endtask

  // One instruction enters at the next edge; the one before it
  // retires there, reading memory before its own store lands.
  task automatic cycle(input tx_t t, input string tag);
    logic [63:0] exp_wb;
    drive(t);
    @(posedge clk);
    #1;
    chk({tag, ":pcsrc"}, 64'(PCSrc), 64'(pc_ref(t)));
    chk({tag, ":baddr"}, oldBranchAddress, t.ba);
    exp_wb = prev.m2r ? mm[idx(prev.res)] : prev.res;
    chk({tag, ":wbdata"}, Data2Write, exp_wb);
    chk({tag, ":wbrd"}, 64'(Reg2Write), 64'(prev.ins[4:0]));
    chk({tag, ":wbrw"}, 64'(oldRegWrite), 64'(prev.rw));
    if (prev.mw) mm[idx(prev.res)] = prev.d2;
    prev = t;
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, ":pcsrc"}, 64'(PCSrc), 64'd0);
    chk({tag, ":baddr"}, oldBranchAddress, 64'd0);
    chk({tag, ":wbdata"}, Data2Write, 64'd0);
    chk({tag, ":wbrd"}, 64'(Reg2Write), 64'd0);
    chk({tag, ":wbrw"}, 64'(oldRegWrite), 64'd0);
  endtask

  task automatic alu_chk(input logic [1:0] op,
                         input logic [10:0] opc,
                         input logic [3:0] exp,
                         input string tag);
    ALUOp      = op;
    alu_opcode = opc;
    #1;
    chk(tag, 64'(ALUInst), 64'(exp));
  endtask

  initial begin
    tx_t         s;
    logic [15:0] br_tbl;
    logic [10:0] pats [8];
    logic [10:0] opc;
    logic [1:0]  op;
    tx_t         bt;

    pats = '{11'b10001011000, 11'b11001011000,
             11'b10001010000, 11'b10101010000,
             11'b10010001000, 11'b11010001000,
             11'b10010010000, 11'b10110010000};
    br_tbl = 16'hFFE4;
    foreach (mm[i]) mm[i] = '0;

    reset_n    = 1'b0;
    drive('0);
    ALUOp      = 2'd0;
    alu_opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
    prev    = '0;

    for (int i = 0; i < 256; i++) begin
      cycle(mem_tx(1, 0, 0, 0, 64'(i) << 3, 64'd0, 5'd0), "clr");
    end

    cycle(mem_tx(1, 0, 0, 0, 64'h10, 64'hDEADBEEF, 5'd0), "st");
    cycle(mem_tx(0, 1, 1, 1, 64'h10, 64'd0, 5'd5), "ld");
    cycle('0, "nop");
    chk("stld:data", Data2Write, 64'hDEADBEEF);
    chk("stld:rd", 64'(Reg2Write), 64'd5);
    chk("stld:rw", 64'(oldRegWrite), 64'd1);

    cycle(mem_tx(0, 0, 0, 1, 64'h1234, 64'd0, 5'd7), "pass");
    cycle('0, "nop");
    chk("pass:data", Data2Write, 64'h1234);

    cycle(mem_tx(1, 0, 0, 0, 64'h808, 64'hCAFEF00D12345678, 5'd0), "wst");
    cycle(mem_tx(0, 1, 1, 1, 64'h008, 64'd0, 5'd9), "wld");
    cycle('0, "nop");
    chk("wrap:data", Data2Write, 64'hCAFEF00D12345678);

    cycle(mem_tx(1, 1, 1, 1, 64'h10, 64'h5555, 5'd3), "rw");
    cycle('0, "nop");
    chk("rwsame:old", Data2Write, 64'hDEADBEEF);
    cycle(mem_tx(0, 1, 1, 1, 64'h10, 64'd0, 5'd4), "rwld");
    cycle('0, "nop");
    chk("rwsame:new", Data2Write, 64'h5555);

    for (int i = 0; i < 16; i++) begin
      bt    = '0;
      bt.ba = 64'h100;
      {bt.b, bt.bz, bt.bnz, bt.z} = 4'(i);
      cycle(bt, "br");
      chk("br:truth", 64'(PCSrc), 64'(br_tbl[i]));
      chk("br:addr", oldBranchAddress, 64'h100);
    end

    cycle(mem_tx(1, 0, 0, 0, 64'h40, 64'h1111, 5'd0), "s1");
    cycle('0, "nop");
    s    = mem_tx(1, 0, 0, 0, 64'h40, 64'h2222, 5'd0);
    s.b  = 1'b1;
    s.ba = 64'hABC;
    cycle(s, "s2");
    #3;
    reset_n = 1'b0;
    #1;
    reset_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    prev    = '0;
    cycle(mem_tx(0, 1, 1, 1, 64'h40, 64'd0, 5'd6), "ld40");
    cycle('0, "nop");
    chk("midrst:keep", Data2Write, 64'h1111);

    for (int i = 0; i < 400; i++) begin
      cycle(rand_tx(), "rnd");
    end

    alu_chk(2'b10, 11'b11001011000, 4'b0110, "alu:sub");
    alu_chk(2'b11, 11'b10110010000, 4'b0001, "alu:orri");
    alu_chk(2'b00, 11'($urandom), 4'b0010, "alu:ld");
    alu_chk(2'b01, 11'($urandom), 4'b0111, "alu:cbz");
    alu_chk(2'b10, 11'b00000000000, 4'b1111, "alu:bad");
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom);
      opc = pats[$urandom_range(0, 7)] ^ 11'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) opc = 11'($urandom);
      alu_chk(op, opc, alu_ref(op, opc), "alu:rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
